// File: rtl/hist_serial_scheduler.sv
// Round-robin scheduler that frames one histogram word at a time onto a byte-wide
// valid/ready port: header, 8 data bytes LSB first, XOR checksum of the data bytes.
//
// state | meaning
// IDLE  | no frame in flight; grant the next requester when enabled
// HDR   | header byte presented
// DATA  | data byte byte_cnt presented
// CSUM  | checksum byte presented
module hist_serial_scheduler #(
  parameter int          NREQ     = 4,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic              clk50,
  input  logic              rstn,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*64-1:0] hist_flat,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [15:0]       frame_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [63:0]     shadow_q, shadow_d;
  logic [7:0]      csum_q, csum_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]   last_gnt_q, last_gnt_d;

  logic            found;
  logic [IW-1:0]   win, cand;
  logic [63:0]     win_word;
  logic [2:0]      next_cnt;
  logic            hs;

  // Search starts just after the previous winner so a held request cannot starve others.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_gnt_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) win_word = hist_flat[i*64 +: 64];
    end
  end

  assign hs       = tx_valid_q && tx_ready;
  assign next_cnt = byte_cnt_q + 3'd1;

  always_comb begin
    state_d       = state_q;
    gnt_d         = '0;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    frame_count_d = frame_count_q;
    shadow_d      = shadow_q;
    csum_d        = csum_q;
    byte_cnt_d    = byte_cnt_q;
    last_gnt_d    = last_gnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable && found) begin
          shadow_d   = win_word;
          gnt_d      = NREQ'(1) << win;
          last_gnt_d = win;
          tx_data_d  = HDR_BASE | 8'(win);
          tx_valid_d = 1'b1;
          csum_d     = 8'h00;
          state_d    = S_HDR;
        end
      end
      S_HDR: begin
        if (hs) begin
          state_d    = S_DATA;
          byte_cnt_d = 3'd0;
          tx_data_d  = shadow_q[7:0];
        end
      end
      S_DATA: begin
        if (hs) begin
          csum_d = csum_q ^ tx_data_q;
          if (byte_cnt_q != 3'd7) begin
            byte_cnt_d = next_cnt;
            tx_data_d  = shadow_q[{next_cnt, 3'b000} +: 8];
          end else begin
            state_d   = S_CSUM;
            tx_data_d = csum_q ^ tx_data_q;
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          tx_valid_d    = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk50 or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      gnt_q         <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= 16'h0000;
      shadow_q      <= 64'h0;
      csum_q        <= 8'h00;
      byte_cnt_q    <= 3'd0;
      last_gnt_q    <= IW'(NREQ - 1);
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      shadow_q      <= shadow_d;
      csum_q        <= csum_d;
      byte_cnt_q    <= byte_cnt_d;
      last_gnt_q    <= last_gnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_hist_serial_scheduler.sv
// Directed bench for hist_serial_scheduler: framing, round robin, backpressure,
// shadowing, enable gating, reset and frame counter wrap.
module tb_hist_serial_scheduler;

  logic         clk50 = 1'b0;
  logic         rstn = 1'b0;
  logic         enable = 1'b0;
  logic         tx_ready = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [255:0] hist_flat = '0;
  logic [3:0]   gnt;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         busy;
  logic [15:0]  frame_count;

  hist_serial_scheduler #(.NREQ(4), .HDR_BASE(8'hA0)) dut (
    .clk50(clk50), .rstn(rstn), .enable(enable), .req(req), .hist_flat(hist_flat),
    .gnt(gnt), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk50 = ~clk50;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_err = 0;
  int stall_seen = 0;
  logic [7:0] bytes_q[$];
  logic [3:0] gnt_log[$];
  int         gnt_cyc[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] exp_single [10] = '{8'hA2, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
  logic [7:0] exp_shadow [10] = '{8'hA3, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88};

  always @(posedge clk50) cyc = cyc + 1;

  // Records accepted bytes, grant pulses and any change of a stalled byte.
  always @(negedge clk50) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
      if (gnt != 4'b0000) begin
        gnt_log.push_back(gnt);
        gnt_cyc.push_back(cyc);
      end
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
      prev_stall = tx_valid && !tx_ready;
      if (prev_stall) stall_seen++;
      prev_data = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk50);
    #2;
  endtask

  task automatic clear_logs();
    bytes_q.delete();
    gnt_log.delete();
    gnt_cyc.delete();
    stall_err = 0;
    stall_seen = 0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk50);
      if (bytes_q.size() >= n && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk50);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (frame_count !== 16'h0000) begin fails++; $display("FAIL reset_count got %h want 0000", frame_count); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    bit ok;
    clear_logs();
    hist_flat[2*64 +: 64] = 64'h0807060504030201;
    enable = 1'b1;
    tx_ready = 1'b1;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'hA2) begin fails++; $display("FAIL single_latency got valid=%b data=%h want 1/a2", tx_valid, tx_data); end
    wait_done(10, 40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_timeout got %0d bytes want 10", bytes_q.size()); end
    repeat (3) tick();
    tests++; if (bytes_q.size() != 10) begin fails++; $display("FAIL single_len got %0d want 10", bytes_q.size()); end
    for (int i = 0; i < 10 && i < bytes_q.size(); i++) begin
      tests++; if (bytes_q[i] !== exp_single[i]) begin fails++; $display("FAIL single_byte%0d got %h want %h", i, bytes_q[i], exp_single[i]); end
    end
    tests++; if (gnt_log.size() != 1 || gnt_log[0] !== 4'b0100) begin fails++; $display("FAIL single_gnt got %0d pulses want 1 of 0100", gnt_log.size()); end
    tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL single_count got %0d want 1", frame_count); end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    hist_flat[0 +: 64] = 64'h1111_2222_3333_4444;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (3) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rstn = 1'b0;
    #1;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL mid_tx_valid got %b want 0", tx_valid); end
    tests++; if (frame_count !== 16'h0000) begin fails++; $display("FAIL mid_count got %h want 0000", frame_count); end
    tests++; if (busy !== 1'b0 || gnt !== 4'b0000 || tx_data !== 8'h00) begin fails++; $display("FAIL mid_outputs got busy=%b gnt=%b data=%h want 0/0000/00", busy, gnt, tx_data); end
    tick();
    tick();
    rstn = 1'b1;
    clear_logs();
    repeat (5) tick();
    tests++; if (busy !== 1'b0 || gnt_log.size() != 0 || bytes_q.size() != 0) begin fails++; $display("FAIL mid_after got busy=%b grants=%0d bytes=%0d want idle", busy, gnt_log.size(), bytes_q.size()); end
    tests++; if (frame_count !== 16'h0000) begin fails++; $display("FAIL mid_count_after got %h want 0000", frame_count); end
  endtask

  task automatic test_round_robin();
    bit done;
    done = 1'b0;
    clear_logs();
    req = 4'b1111;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (gnt_log.size() >= 8) req = 4'b0000;
      if (gnt_log.size() >= 8 && bytes_q.size() >= 80 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL rr_timeout got %0d bytes want 80", bytes_q.size()); end
    repeat (3) tick();
    tests++; if (bytes_q.size() != 80 || gnt_log.size() != 8) begin fails++; $display("FAIL rr_len got bytes=%0d grants=%0d want 80/8", bytes_q.size(), gnt_log.size()); end
    for (int k = 0; k < 8 && 10*k < bytes_q.size() && k < gnt_log.size(); k++) begin
      tests++; if (bytes_q[10*k] !== (8'hA0 | 8'(k % 4))) begin fails++; $display("FAIL rr_hdr%0d got %h want %h", k, bytes_q[10*k], 8'hA0 | 8'(k % 4)); end
      tests++; if (gnt_log[k] !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_gnt%0d got %b want %b", k, gnt_log[k], 4'(1 << (k % 4))); end
    end
    for (int k = 0; k + 1 < gnt_cyc.size(); k++) begin
      tests++; if (gnt_cyc[k+1] - gnt_cyc[k] != 11) begin fails++; $display("FAIL rr_period%0d got %0d want 11", k, gnt_cyc[k+1] - gnt_cyc[k]); end
    end
    tests++; if (frame_count !== 16'd8) begin fails++; $display("FAIL rr_count got %0d want 8", frame_count); end
  endtask

  task automatic test_backpressure();
    bit done;
    done = 1'b0;
    clear_logs();
    tx_ready = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 80; i++) begin
      tick();
      req = 4'b0000;
      tx_ready = (i % 3 == 0);
      if (bytes_q.size() >= 10 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    tx_ready = 1'b1;
    tests++; if (!done) begin fails++; $display("FAIL bp_timeout got %0d bytes want 10", bytes_q.size()); end
    repeat (3) tick();
    tests++; if (bytes_q.size() != 10) begin fails++; $display("FAIL bp_len got %0d want 10", bytes_q.size()); end
    for (int i = 0; i < 10 && i < bytes_q.size(); i++) begin
      tests++; if (bytes_q[i] !== exp_single[i]) begin fails++; $display("FAIL bp_byte%0d got %h want %h", i, bytes_q[i], exp_single[i]); end
    end
    tests++; if (stall_err != 0 || stall_seen == 0) begin fails++; $display("FAIL bp_stable got changes=%0d stalls=%0d want 0/>0", stall_err, stall_seen); end
    tests++; if (gnt_log.size() != 1) begin fails++; $display("FAIL bp_gnt got %0d pulses want 1", gnt_log.size()); end
  endtask

  task automatic test_shadow_enable();
    bit ok;
    clear_logs();
    hist_flat[3*64 +: 64] = 64'h1122334455667788;
    req = 4'b1000;
    tick();
    hist_flat[3*64 +: 64] = 64'hCAFEBABEDEADBEEF;
    tick();
    tick();
    enable = 1'b0;
    wait_done(10, 40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL sh_timeout got %0d bytes want 10", bytes_q.size()); end
    repeat (20) tick();
    for (int i = 0; i < 10 && i < bytes_q.size(); i++) begin
      tests++; if (bytes_q[i] !== exp_shadow[i]) begin fails++; $display("FAIL sh_byte%0d got %h want %h", i, bytes_q[i], exp_shadow[i]); end
    end
    tests++; if (gnt_log.size() != 1 || busy !== 1'b0) begin fails++; $display("FAIL en_hold got grants=%0d busy=%b want 1/0", gnt_log.size(), busy); end
    enable = 1'b1;
    tick();
    req = 4'b0000;
    wait_done(20, 40, ok);
    tests++; if (!ok || gnt_log.size() != 2) begin fails++; $display("FAIL en_resume got bytes=%0d grants=%0d want 20/2", bytes_q.size(), gnt_log.size()); end
    if (bytes_q.size() >= 12) begin
      tests++; if (bytes_q[10] !== 8'hA3 || bytes_q[11] !== 8'hEF) begin fails++; $display("FAIL en_new_word got %h %h want a3 ef", bytes_q[10], bytes_q[11]); end
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    clear_logs();
    req = 4'b0010;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (gnt_log.size() >= 3) req = 4'b0000;
      if (gnt_log.size() >= 3 && bytes_q.size() >= 30 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    tests++; if (!done || gnt_log.size() != 3) begin fails++; $display("FAIL b2b_done got grants=%0d bytes=%0d want 3/30", gnt_log.size(), bytes_q.size()); end
    for (int k = 0; k < gnt_log.size(); k++) begin
      tests++; if (gnt_log[k] !== 4'b0010) begin fails++; $display("FAIL b2b_gnt%0d got %b want 0010", k, gnt_log[k]); end
    end
    for (int k = 0; k + 1 < gnt_cyc.size(); k++) begin
      tests++; if (gnt_cyc[k+1] - gnt_cyc[k] != 11) begin fails++; $display("FAIL b2b_period%0d got %0d want 11", k, gnt_cyc[k+1] - gnt_cyc[k]); end
    end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    tests++; if (frame_count !== 16'd14) begin fails++; $display("FAIL wrap_pre got %0d want 14", frame_count); end
    @(negedge clk50);
    force dut.frame_count_d = 16'hFFFF;
    @(posedge clk50);
    #1;
    release dut.frame_count_d;
    tests++; if (frame_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_load got %h want ffff", frame_count); end
    clear_logs();
    #1;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    wait_done(10, 40, ok);
    tests++; if (!ok || frame_count !== 16'h0000) begin fails++; $display("FAIL wrap_count got %h want 0000", frame_count); end
    if (bytes_q.size() > 0) begin
      tests++; if (bytes_q[0] !== 8'hA0) begin fails++; $display("FAIL wrap_hdr got %h want a0", bytes_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_reset_midframe();
    test_round_robin();
    test_backpressure();
    test_shadow_enable();
    test_back_to_back();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
